calc_axis_times: RTL and testbench

//  Motion-planner stage 2: turns per-axis step-profile parameters (from speeds_to_timings)

---
 rtl/motion_pkg.sv | 40 ++++
 rtl/calc_axis_times_if.sv | 33 +++
 rtl/axis_time_calc.sv | 66 ++++++
 rtl/calc_axis_times.sv | 95 +++++++++
 tb/tb_calc_axis_times.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/motion_pkg.sv
// Types and constants shared by the motion-planner stages.
// Covers parameter/timing word layout, the stage FSM encoding, and the saturation helper.
package motion_pkg;

    localparam int PW = 32;
    localparam int TW = 64;

    localparam int N_AXES  = 5;
    localparam int PROD_W  = 2 * PW;
    localparam int DTERM_W = 3 * PW;
    localparam int SUM_W   = DTERM_W + 2;

    localparam int P_NA = 0;
    localparam int P_NC = 1;
    localparam int P_T0 = 2;
    localparam int P_D  = 3;
    localparam int P_TC = 4;

    localparam int T_ACC = 0;
    localparam int T_CRU = 1;
    localparam int T_DEC = 2;
    localparam int T_TOT = 3;

    typedef logic [4:0][PW-1:0] params_t;
    typedef logic [3:0][TW-1:0] timing_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_MUL,
        S_SUM,
        S_DONE
    } calc_state_e;

    // Any set bit at or above TW means the value cannot be represented.
    function automatic logic [TW-1:0] sat_tw(input logic [SUM_W-1:0] v);
        return (|(v >> TW)) ? '1 : TW'(v);
    endfunction

endpackage

// File: rtl/calc_axis_times_if.sv
// Request/response bundle between the planner and calc_axis_times.
// Carries a start pulse, five per-axis parameter sets, five timing sets, and the finish pulse.
interface calc_axis_times_if;
    import motion_pkg::*;

    logic    start;
    params_t params_x;
    params_t params_y;
    params_t params_z;
    params_t params_e0;
    params_t params_e1;
    timing_t timing_x;
    timing_t timing_y;
    timing_t timing_z;
    timing_t timing_e0;
    timing_t timing_e1;
    logic    finish;

    modport master (
        output start,
        output params_x, params_y, params_z, params_e0, params_e1,
        input  timing_x, timing_y, timing_z, timing_e0, timing_e1,
        input  finish
    );

    modport slave (
        input  start,
        input  params_x, params_y, params_z, params_e0, params_e1,
        output timing_x, timing_y, timing_z, timing_e0, timing_e1,
        output finish
    );

endinterface

// File: rtl/axis_time_calc.sv
// One axis of the phase-duration datapath: captured parameters, two product stages,
// then clamp of the accel term and saturation of every timing word.
module axis_time_calc
    import motion_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    capture,
    input  logic    mul_en,
    input  logic    dterm_en,
    input  logic    sum_en,
    input  params_t params,
    output timing_t timing
);

    params_t              p_q;
    logic [PROD_W-1:0]    na_t0_q;
    logic [PROD_W-1:0]    na_tri_q;
    logic [PROD_W-1:0]    nc_tc_q;
    logic [DTERM_W-1:0]   dterm_q;

    logic [PW-1:0]        na_m1;
    logic [DTERM_W-1:0]   ta_full;
    logic [SUM_W-1:0]     tot_full;
    logic [TW-1:0]        ta_sat;

    // Na=0 wraps Na-1 to all-ones, but the product with Na=0 is still zero.
    assign na_m1 = p_q[P_NA] - PW'(1);

    assign ta_full  = (dterm_q > DTERM_W'(na_t0_q)) ? '0
                                                    : DTERM_W'(na_t0_q) - dterm_q;
    assign tot_full = SUM_W'(ta_full) + SUM_W'(ta_full) + SUM_W'(nc_tc_q);
    assign ta_sat   = sat_tw(SUM_W'(ta_full));

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the operand and product registers are reset too, so an aborted run leaves nothing stale.
            p_q      <= '0;
            na_t0_q  <= '0;
            na_tri_q <= '0;
            nc_tc_q  <= '0;
            dterm_q  <= '0;
            timing   <= '0;
        end else begin
            if (capture) begin
                p_q <= params;
            end
            if (mul_en) begin
                na_t0_q  <= PROD_W'(p_q[P_NA]) * PROD_W'(p_q[P_T0]);
                na_tri_q <= PROD_W'(p_q[P_NA]) * PROD_W'(na_m1);
                nc_tc_q  <= PROD_W'(p_q[P_NC]) * PROD_W'(p_q[P_TC]);
            end
            if (dterm_en) begin
                dterm_q <= DTERM_W'(p_q[P_D]) * DTERM_W'(na_tri_q >> 1);
            end
            if (sum_en) begin
                timing[T_ACC] <= ta_sat;
                timing[T_CRU] <= sat_tw(SUM_W'(nc_tc_q));
                timing[T_DEC] <= ta_sat;
                timing[T_TOT] <= sat_tw(tot_full);
            end
        end
    end

endmodule

// File: rtl/calc_axis_times.sv
// Motion-planner stage 2: sequences five axis_time_calc datapaths through
// capture, multiply, multiply, sum, and raises finish for one cycle.
module calc_axis_times
    import motion_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    calc_axis_times_if.slave bus
);

    calc_state_e state_q;
    calc_state_e state_d;
    logic        capture;
    logic        mul_en;
    logic        dterm_en;
    logic        sum_en;
    logic        finish;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: defaults first, so no path through the case leaves an output unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        mul_en   = 1'b0;
        dterm_en = 1'b0;
        sum_en   = 1'b0;
        finish   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    capture = 1'b1;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                mul_en  = 1'b1;
                state_d = S_MUL;
            end
            S_MUL: begin
                dterm_en = 1'b1;
                state_d  = S_SUM;
            end
            S_SUM: begin
                sum_en  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.finish = finish;

    // Start outside IDLE never reaches capture, so a busy request is simply dropped.
    axis_time_calc u_axis_x (
        .clk(clk), .reset(reset), .capture(capture), .mul_en(mul_en),
        .dterm_en(dterm_en), .sum_en(sum_en),
        .params(bus.params_x), .timing(bus.timing_x)
    );

    axis_time_calc u_axis_y (
        .clk(clk), .reset(reset), .capture(capture), .mul_en(mul_en),
        .dterm_en(dterm_en), .sum_en(sum_en),
        .params(bus.params_y), .timing(bus.timing_y)
    );

    axis_time_calc u_axis_z (
        .clk(clk), .reset(reset), .capture(capture), .mul_en(mul_en),
        .dterm_en(dterm_en), .sum_en(sum_en),
        .params(bus.params_z), .timing(bus.timing_z)
    );

    axis_time_calc u_axis_e0 (
        .clk(clk), .reset(reset), .capture(capture), .mul_en(mul_en),
        .dterm_en(dterm_en), .sum_en(sum_en),
        .params(bus.params_e0), .timing(bus.timing_e0)
    );

    axis_time_calc u_axis_e1 (
        .clk(clk), .reset(reset), .capture(capture), .mul_en(mul_en),
        .dterm_en(dterm_en), .sum_en(sum_en),
        .params(bus.params_e1), .timing(bus.timing_e1)
    );

endmodule

// File: tb/tb_calc_axis_times.sv
// Directed-vector bench for calc_axis_times with hand-computed phase durations.
module tb_calc_axis_times;
    import motion_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   fin_cnt = 0;

    always #5 clk = ~clk;

    calc_axis_times_if bus ();

    calc_axis_times dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always @(negedge clk) if (bus.finish === 1'b1) fin_cnt++;

    function automatic params_t mk_p(input logic [PW-1:0] na, nc, t0, d, tc);
        params_t p;
        p[P_NA] = na; p[P_NC] = nc; p[P_T0] = t0; p[P_D] = d; p[P_TC] = tc;
        return p;
    endfunction

    function automatic timing_t mk_t(input logic [TW-1:0] ta, tcr, td, tot);
        timing_t t;
        t[T_ACC] = ta; t[T_CRU] = tcr; t[T_DEC] = td; t[T_TOT] = tot;
        return t;
    endfunction

    function automatic timing_t axis_timing(input int a);
        case (a)
            0: return bus.timing_x;
            1: return bus.timing_y;
            2: return bus.timing_z;
            3: return bus.timing_e0;
            default: return bus.timing_e1;
        endcase
    endfunction

    task automatic set_axis(input int a, input params_t p);
        case (a)
            0: bus.params_x = p;
            1: bus.params_y = p;
            2: bus.params_z = p;
            3: bus.params_e0 = p;
            default: bus.params_e1 = p;
        endcase
    endtask

    // Called just after a falling edge; returns just after the falling edge following edge 0.
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Latency in cycles counted from the edge that sampled start; -1 if finish never came.
    task automatic wait_finish(output int lat);
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.finish === 1'b1) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input timing_t exp [N_AXES]);
        int lat;
        int snap;
        snap = fin_cnt;
        pulse_start();
        wait_finish(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL %s_latency got %0d want 4", name, lat);
        end
        for (int a = 0; a < N_AXES; a++) begin
            checks++;
            if (axis_timing(a) !== exp[a]) begin
                errors++;
                $display("FAIL %s_axis%0d got %h want %h", name, a, axis_timing(a), exp[a]);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (fin_cnt - snap !== 1) begin
            errors++;
            $display("FAIL %s_pulses got %0d want 1", name, fin_cnt - snap);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        for (int a = 0; a < N_AXES; a++) set_axis(a, '0);
        repeat (3) @(negedge clk);
        for (int a = 0; a < N_AXES; a++) begin
            checks++;
            if (axis_timing(a) !== '0) begin
                errors++;
                $display("FAIL reset_axis%0d got %h want 0", a, axis_timing(a));
            end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.finish !== 1'b0) begin
            errors++;
            $display("FAIL reset_finish got %b want 0", bus.finish);
        end
    endtask

    task automatic test_basic();
        timing_t exp [N_AXES];
        set_axis(0, mk_p(4, 10, 100, 10, 50));
        set_axis(1, mk_p(1, 3, 77, 5, 9));
        set_axis(2, mk_p(2, 0, 20, 3, 5));
        set_axis(3, mk_p(0, 4, 50, 1, 0));
        set_axis(4, mk_p(5, 1, 30, 5, 100));
        exp[0] = mk_t(340, 500, 340, 1180);
        exp[1] = mk_t(77, 27, 77, 181);
        exp[2] = mk_t(37, 0, 37, 74);
        exp[3] = mk_t(0, 0, 0, 0);
        exp[4] = mk_t(100, 100, 100, 300);
        run_op("basic", exp);
    endtask

    task automatic test_zero();
        timing_t exp [N_AXES];
        for (int a = 0; a < N_AXES; a++) begin
            set_axis(a, mk_p(0, 0, 123, 4, 9));
            exp[a] = mk_t(0, 0, 0, 0);
        end
        run_op("zero", exp);
    endtask

    task automatic test_clamp();
        timing_t exp [N_AXES];
        set_axis(0, mk_p(3, 2, 5, 10, 7));
        set_axis(1, mk_p(3, 1, 10, 10, 1));
        set_axis(2, mk_p(3, 0, 11, 10, 9));
        set_axis(3, mk_p(1, 0, 8, 1000, 0));
        set_axis(4, mk_p(2, 1, 1, 3, 1));
        exp[0] = mk_t(0, 14, 0, 14);
        exp[1] = mk_t(0, 1, 0, 1);
        exp[2] = mk_t(3, 0, 3, 6);
        exp[3] = mk_t(8, 0, 8, 16);
        exp[4] = mk_t(0, 1, 0, 1);
        run_op("clamp", exp);
    endtask

    task automatic test_saturate();
        timing_t exp [N_AXES];
        logic [TW-1:0] sq;
        sq = 64'hFFFF_FFFE_0000_0001;
        set_axis(0, mk_p(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFF));
        set_axis(1, mk_p(32'hFFFFFFFF, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF));
        set_axis(2, mk_p(0, 32'hFFFFFFFF, 7, 7, 32'hFFFFFFFF));
        set_axis(3, mk_p(0, 0, 0, 0, 0));
        set_axis(4, mk_p(0, 0, 0, 0, 0));
        exp[0] = mk_t(sq, sq, sq, 64'hFFFF_FFFF_FFFF_FFFF);
        exp[1] = mk_t(0, 0, 0, 0);
        exp[2] = mk_t(0, sq, 0, sq);
        exp[3] = mk_t(0, 0, 0, 0);
        exp[4] = mk_t(0, 0, 0, 0);
        run_op("saturate", exp);
    endtask

    task automatic test_back_to_back();
        timing_t exp_a;
        timing_t exp_b;
        int snap;
        int lat;
        exp_a = mk_t(17, 12, 17, 46);
        exp_b = mk_t(210, 50, 210, 470);
        for (int a = 1; a < N_AXES; a++) set_axis(a, '0);
        snap = fin_cnt;
        set_axis(0, mk_p(2, 3, 9, 1, 4));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        set_axis(0, mk_p(6, 5, 40, 2, 10));
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.finish !== 1'b1) begin
            errors++;
            $display("FAIL b2b_finish_cycle4 got %b want 1", bus.finish);
        end
        checks++;
        if (bus.timing_x !== exp_a) begin
            errors++;
            $display("FAIL b2b_first got %h want %h", bus.timing_x, exp_a);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fin_cnt - snap !== 1) begin
            errors++;
            $display("FAIL b2b_pulses got %0d want 1", fin_cnt - snap);
        end
        pulse_start();
        checks++;
        if (bus.timing_x !== exp_a) begin
            errors++;
            $display("FAIL b2b_hold got %h want %h", bus.timing_x, exp_a);
        end
        wait_finish(lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL b2b_latency got %0d want 4", lat);
        end
        checks++;
        if (bus.timing_x !== exp_b) begin
            errors++;
            $display("FAIL b2b_second got %h want %h", bus.timing_x, exp_b);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        timing_t exp [N_AXES];
        int snap;
        for (int a = 0; a < N_AXES; a++) begin
            set_axis(a, '0);
            exp[a] = mk_t(0, 0, 0, 0);
        end
        set_axis(0, mk_p(4, 10, 100, 10, 50));
        exp[0] = mk_t(340, 500, 340, 1180);
        snap = fin_cnt;
        pulse_start();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.timing_x !== '0) begin
            errors++;
            $display("FAIL midreset_clear got %h want 0", bus.timing_x);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (fin_cnt !== snap) begin
            errors++;
            $display("FAIL midreset_no_finish got %0d pulses want 0", fin_cnt - snap);
        end
        checks++;
        if (bus.timing_x !== '0) begin
            errors++;
            $display("FAIL midreset_stay_clear got %h want 0", bus.timing_x);
        end
        run_op("after_reset", exp);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_clamp();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
